io_spi_master: RTL and testbench

Parameterised SPI master shift engine: on a one-cycle `start_tx` pulse it latches a `WIDTH`-bit word, drives it out on `spi_mosi` under chip select and a divided serial clock, captures `spi_miso` in parallel, and pulses `done_tx` when the frame is complete. Device-initialisation sequencers (monitor, clock, converter set-up) instantiate it as their SPI write/read transport, one frame per ROM entry.

---
 rtl/io_spi_master.sv | 175 +++++++++++++++++
 tb/tb_io_spi_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_spi_master.sv
// SPI mode-0 master shift engine: one WIDTH-bit frame per accepted start_tx pulse.
// Define IO_SPI_MISO_EN to include the receive path; otherwise rx_data is tied to zero.
module io_spi_master #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FLIP      = 0,
    parameter int unsigned SCLK_TIME = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tx,
    output logic             done_tx,
    output logic             spi_clk,
    output logic             spi_mosi,
    output logic             spi_cs,
    input  logic             spi_miso,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data
);

    localparam int unsigned HW = $clog2(SCLK_TIME) + 1;
    localparam int unsigned BW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             half_last_c;
    logic             frame_c;

`ifdef IO_SPI_MISO_EN
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
`else
    logic             unused_miso;
    assign unused_miso = spi_miso;
`endif

    assign half_last_c = (hcnt_q == HW'(SCLK_TIME - 1));

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        tx_d    = tx_q;
`ifdef IO_SPI_MISO_EN
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_tx) begin
                    tx_d    = tx_data;
                    bcnt_d  = BW'(WIDTH - 1);
                    hcnt_d  = '0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (half_last_c) begin
                    hcnt_d  = '0;
                    state_d = SHIFT_HI;
`ifdef IO_SPI_MISO_EN
                    // MISO is sampled on the same edge that raises spi_clk.
                    if (FLIP != 0) begin
                        rx_d = (rx_q >> 1) | (WIDTH'(spi_miso) << (WIDTH - 1));
                    end else begin
                        rx_d = (rx_q << 1) | WIDTH'(spi_miso);
                    end
`endif
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            SHIFT_HI: begin
                if (half_last_c) begin
                    hcnt_d = '0;
                    if (bcnt_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        bcnt_d  = bcnt_q - BW'(1);
                        tx_d    = (FLIP != 0) ? (tx_q >> 1) : (tx_q << 1);
                        state_d = SHIFT_LO;
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            HOLD: begin
                if (half_last_c) begin
                    hcnt_d  = '0;
                    state_d = DONE;
`ifdef IO_SPI_MISO_EN
                    rx_data_d = rx_q;
`endif
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        frame_c = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == HOLD);
        cs_d    = ~frame_c;
        sclk_d  = (state_d == SHIFT_HI);
        mosi_d  = 1'b0;
        if (frame_c) begin
            mosi_d = (FLIP != 0) ? tx_d[0] : tx_d[WIDTH-1];
        end
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

`ifdef IO_SPI_MISO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_q      <= '0;
            rx_data_q <= '0;
        end else begin
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    assign rx_data = '0;
`endif

    assign spi_cs   = cs_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign done_tx  = done_q;

endmodule

// File: tb/tb_io_spi_master.sv
// Directed self-checking bench for io_spi_master: three configurations with MOSI->MISO loopback.
module tb_io_spi_master;

`ifdef IO_SPI_MISO_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    int          sel = 0;
    logic [31:0] txd = '0;

    logic        start0, start1, start2;
    logic        done0, done1, done2;
    logic        sclk0, sclk1, sclk2;
    logic        mosi0, mosi1, mosi2;
    logic        cs0, cs1, cs2;
    logic [31:0] rx0;
    logic [7:0]  rx1;
    logic [3:0]  rx2;

    logic        cs_s, sclk_s, mosi_s, done_s;
    logic [31:0] rx_s;

    int          checks = 0;
    int          failures = 0;

    int          cs_low, rises, hi_cnt, done_n, done_at, first_cs, first_rise;
    logic [31:0] bits, rx_at;

    always #5 clk = ~clk;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    io_spi_master u_dut0 (
        .clk(clk), .rst(rst), .start_tx(start0), .done_tx(done0), .spi_clk(sclk0),
        .spi_mosi(mosi0), .spi_cs(cs0), .spi_miso(mosi0), .tx_data(txd), .rx_data(rx0)
    );

    io_spi_master #(.WIDTH(8), .FLIP(1), .SCLK_TIME(2)) u_dut1 (
        .clk(clk), .rst(rst), .start_tx(start1), .done_tx(done1), .spi_clk(sclk1),
        .spi_mosi(mosi1), .spi_cs(cs1), .spi_miso(mosi1), .tx_data(txd[7:0]), .rx_data(rx1)
    );

    io_spi_master #(.WIDTH(4), .FLIP(0), .SCLK_TIME(1)) u_dut2 (
        .clk(clk), .rst(rst), .start_tx(start2), .done_tx(done2), .spi_clk(sclk2),
        .spi_mosi(mosi2), .spi_cs(cs2), .spi_miso(mosi2), .tx_data(txd[3:0]), .rx_data(rx2)
    );

    always_comb begin
        cs_s   = cs0;
        sclk_s = sclk0;
        mosi_s = mosi0;
        done_s = done0;
        rx_s   = rx0;
        if (sel == 1) begin
            cs_s = cs1; sclk_s = sclk1; mosi_s = mosi1; done_s = done1; rx_s = 32'(rx1);
        end else if (sel == 2) begin
            cs_s = cs2; sclk_s = sclk2; mosi_s = mosi2; done_s = done2; rx_s = 32'(rx2);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start, then watch ncyc cycles (cycle 1 = first cycle after the accepting edge).
    task automatic run(input int s, input logic [31:0] d, input int inj_a, input int inj_b,
                       input int ncyc);
        logic prev_clk;
        sel = s;
        txd = d;
        cs_low = 0; rises = 0; hi_cnt = 0; done_n = 0;
        done_at = -1; first_cs = -1; first_rise = -1;
        bits = '0; rx_at = '0; prev_clk = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            start = (i == inj_a) || (i == inj_b);
            if (!cs_s) begin
                cs_low++;
                if (first_cs < 0) first_cs = i;
            end
            if (sclk_s) hi_cnt++;
            if (sclk_s && !prev_clk) begin
                rises++;
                bits = {bits[30:0], mosi_s};
                if (first_rise < 0) first_rise = i;
            end
            prev_clk = sclk_s;
            if (done_s) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i;
                    rx_at = rx_s;
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int dn;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs0), 32'd1);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_mosi", 32'(mosi0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_rx", rx0, 32'd0);
        rst = 1'b1;

        // Basic default frame
        run(0, 32'h000AFFFF, -1, -1, 300);
        check("f0_cs_low", 32'(cs_low), 32'd260);
        check("f0_first_cs", 32'(first_cs), 32'd1);
        check("f0_first_rise", 32'(first_rise), 32'd5);
        check("f0_rises", 32'(rises), 32'd32);
        check("f0_bits", bits, 32'h000AFFFF);
        check("f0_done_n", 32'(done_n), 32'd1);
        check("f0_done_at", 32'(done_at), 32'd261);
        check("f0_rx", rx_at, RX_EN ? 32'h000AFFFF : 32'd0);

        // Starts mid-frame and in the DONE cycle are ignored
        run(0, 32'h010E0B16, 50, 261, 320);
        check("ign_cs_low", 32'(cs_low), 32'd260);
        check("ign_done_n", 32'(done_n), 32'd1);
        check("ign_done_at", 32'(done_at), 32'd261);
        check("ign_rx", rx_at, RX_EN ? 32'h010E0B16 : 32'd0);

        // Start one cycle after done is accepted
        run(0, 32'h5A5AC3C3, 262, -1, 600);
        check("b2b_cs_low", 32'(cs_low), 32'd520);
        check("b2b_rises", 32'(rises), 32'd64);
        check("b2b_done_n", 32'(done_n), 32'd2);
        check("b2b_bits", bits, 32'h5A5AC3C3);

        // LSB-first, 8-bit frames
        run(1, 32'h01, -1, -1, 60);
        check("flip01_bits", 32'(bits[7:0]), 32'h80);
        check("flip01_cs_low", 32'(cs_low), 32'd34);
        check("flip01_done_at", 32'(done_at), 32'd35);
        run(1, 32'hB2, -1, -1, 60);
        check("flipB2_bits", 32'(bits[7:0]), 32'h4D);
        check("flipB2_rx", rx_at, RX_EN ? 32'hB2 : 32'd0);

        // Single-cycle half period, 4-bit frame
        run(2, 32'hA, -1, -1, 20);
        check("fast_cs_low", 32'(cs_low), 32'd9);
        check("fast_rises", 32'(rises), 32'd4);
        check("fast_hi_cnt", 32'(hi_cnt), 32'd4);
        check("fast_bits", 32'(bits[3:0]), 32'hA);
        check("fast_done_at", 32'(done_at), 32'd10);
        check("fast_rx", rx_at, RX_EN ? 32'hA : 32'd0);

        // Asynchronous reset at cycle 100 of a frame
        sel = 0;
        txd = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("mid_cs_low", 32'(cs0), 32'd0);
        rst = 1'b0;
        #1;
        check("arst_cs", 32'(cs0), 32'd1);
        check("arst_sclk", 32'(sclk0), 32'd0);
        check("arst_mosi", 32'(mosi0), 32'd0);
        check("arst_rx", rx0, 32'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done0) dn++;
        end
        rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done0) dn++;
        end
        check("arst_no_done", 32'(dn), 32'd0);
        check("arst_idle_cs", 32'(cs0), 32'd1);

        run(0, 32'h010E0B16, -1, -1, 300);
        check("post_cs_low", 32'(cs_low), 32'd260);
        check("post_done_at", 32'(done_at), 32'd261);
        check("post_bits", bits, 32'h010E0B16);
        check("post_rx", rx_at, RX_EN ? 32'h010E0B16 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
